pc_fetch_unit: RTL and testbench

Parametrised successor to the single-cycle programme counter. Holds the fetch PC and selects the next PC from four prioritised sources: trap vector, execute-stage redirect, BTB prediction and sequential increment. Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained from the execute stage. Sits at the head of the pipeline and feeds the instruction memory address and the IF/ID register.

---
 rtl/pc_pkg.sv | 49 ++++
 rtl/pc_btb.sv | 94 +++++++++
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch unit: defaults, BTB counter encodings,
// next-PC source enum and saturating counter helpers.
package pc_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INCR_DEF = 4;

  // 2-bit saturating branch counter states
  localparam logic [1:0] SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Which source drives the PC register on the next edge, highest priority first
  typedef enum logic [2:0] {
    TRAP  = 3'd0,
    REDIR = 3'd1,
    PRED  = 3'd2,
    SEQ   = 3'd3,
    HOLD  = 3'd4
  } next_src_e;

  // Move one step toward strongly taken, saturating at ST
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      SNT:     r = WNT;
      WNT:     r = WT;
      WT:      r = ST;
      ST:      r = ST;
      default: r = SNT;
    endcase
    return r;
  endfunction

  // Move one step toward strongly not taken, saturating at SNT
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      SNT:     r = SNT;
      WNT:     r = SNT;
      WT:      r = WNT;
      ST:      r = WT;
      default: r = SNT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; training happens on the clock edge, so a lookup
// and an update to the same index in one cycle sees the old contents.
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [XLEN-1:0]  target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             lk_hit_s;
  logic             up_hit_s;
  logic             unused_low_bits_s;

  assign lk_idx_s = lookup_pc[IDX_W+1:2];
  assign lk_tag_s = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx_s = upd_pc[IDX_W+1:2];
  assign up_tag_s = upd_pc[XLEN-1:IDX_W+2];

  // Byte-offset bits never take part in indexing or tagging
  assign unused_low_bits_s = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Combinational lookup for the current fetch PC
  always_comb begin
    lk_hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    pred_taken  = 1'b0;
    pred_target = {XLEN{1'b0}};
    if (lk_hit_s && ctr_r[lk_idx_s][1]) begin
      pred_taken  = 1'b1;
      pred_target = target_r[lk_idx_s];
    end else begin
      pred_taken  = 1'b0;
      pred_target = {XLEN{1'b0}};
    end
  end

  // Hit detection for the training port
  always_comb begin
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
  end

  // Training: counter update on hit, allocation on taken miss
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {XLEN{1'b0}};
        ctr_r[i]    <= SNT;
      end
    end else if (upd_valid) begin
      if (up_hit_s) begin
        if (upd_taken) begin
          ctr_r[up_idx_s]    <= ctr_inc(ctr_r[up_idx_s]);
          target_r[up_idx_s] <= upd_target;
        end else begin
          ctr_r[up_idx_s] <= ctr_dec(ctr_r[up_idx_s]);
        end
      end else if (upd_taken) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= upd_target;
        ctr_r[up_idx_s]    <= WT;
      end else begin
        valid_r[up_idx_s] <= valid_r[up_idx_s];
      end
    end else begin
      valid_r[up_idx_s] <= valid_r[up_idx_s];
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with prioritised next-PC selection
// (trap > redirect > BTB prediction > sequential > hold) and an embedded BTB.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              BTB_ENTRIES  = 16,
  parameter int              INCR         = INCR_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pc_enable,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_next,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] load_addr_s;
  logic            pred_taken_s;
  logic [XLEN-1:0] pred_target_s;
  next_src_e       src_s;

  // Every address loaded into the PC is forced to word alignment
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  pc_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rstn        (rstn),
    .lookup_pc   (pc_r),
    .pred_taken  (pred_taken_s),
    .pred_target (pred_target_s),
    .upd_valid   (btb_upd_valid),
    .upd_pc      (btb_upd_pc),
    .upd_target  (btb_upd_target),
    .upd_taken   (btb_upd_taken)
  );

  // Sequential successor wraps modulo 2^XLEN
  assign pc_next_s = pc_r + XLEN'(INCR);

  // Priority selection; flushes win over a stall
  always_comb begin
    src_s       = HOLD;
    load_addr_s = pc_r;
    if (trap_valid) begin
      src_s       = TRAP;
      load_addr_s = align_word(trap_addr);
    end else if (redirect_valid) begin
      src_s       = REDIR;
      load_addr_s = align_word(redirect_addr);
    end else if (pc_enable && pred_taken_s) begin
      src_s       = PRED;
      load_addr_s = align_word(pred_target_s);
    end else if (pc_enable) begin
      src_s       = SEQ;
      load_addr_s = align_word(pc_next_s);
    end else begin
      src_s       = HOLD;
      load_addr_s = pc_r;
    end
  end

  // PC register update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r <= RESET_VECTOR;
    end else begin
      case (src_s)
        TRAP, REDIR, PRED, SEQ: pc_r <= load_addr_s;
        HOLD:                   pc_r <= pc_r;
        default:                pc_r <= pc_r;
      endcase
    end
  end

  assign pc_current  = pc_r;
  assign pc_next     = pc_next_s;
  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        pc_enable;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .BTB_ENTRIES  (16),
    .INCR         (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pc_enable      (pc_enable),
    .trap_valid     (trap_valid),
    .trap_addr      (trap_addr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .btb_upd_valid  (btb_upd_valid),
    .btb_upd_pc     (btb_upd_pc),
    .btb_upd_target (btb_upd_target),
    .btb_upd_taken  (btb_upd_taken),
    .pc_current     (pc_current),
    .pc_next        (pc_next),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock edge, then land on the following falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    btb_upd_valid  = 1'b1;
    btb_upd_pc     = pc;
    btb_upd_target = tgt;
    btb_upd_taken  = tk;
    step();
    btb_upd_valid  = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pc_enable = 1'b0;
    trap_valid = 1'b0; trap_addr = 32'h0;
    redirect_valid = 1'b0; redirect_addr = 32'h0;
    btb_upd_valid = 1'b0; btb_upd_pc = 32'h0; btb_upd_target = 32'h0; btb_upd_taken = 1'b0;
    step();
    step();

    // Reset state
    check_eq("rst_pc", pc_current, 32'h0);
    check_eq("rst_pc_next", pc_next, 32'h4);
    check_eq("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    check_eq("rst_pred_target", pred_target, 32'h0);

    // 1. sequential fetch
    rstn = 1'b1;
    pc_enable = 1'b1;
    step(); check_eq("seq_4", pc_current, 32'h4);
    step(); check_eq("seq_8", pc_current, 32'h8);
    step(); check_eq("seq_c", pc_current, 32'hC);
    check_eq("seq_pred0", {31'b0, pred_taken}, 32'h0);
    step(); check_eq("seq_10", pc_current, 32'h10);

    // 2. stall, then redirect during the stall
    pc_enable = 1'b0;
    step(); check_eq("stall_hold", pc_current, 32'h10);
    redirect_to(32'h200);
    check_eq("stall_redirect", pc_current, 32'h200);
    step(); check_eq("stall_hold2", pc_current, 32'h200);

    // 3. allocate 0x40 -> 0x100, run from 0x3C
    btb_upd_valid = 1'b1; btb_upd_pc = 32'h40; btb_upd_target = 32'h100; btb_upd_taken = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 32'h3C;
    step();
    btb_upd_valid = 1'b0; redirect_valid = 1'b0;
    check_eq("run_3c", pc_current, 32'h3C);
    check_eq("run_3c_pred", {31'b0, pred_taken}, 32'h0);
    pc_enable = 1'b1;
    step();
    check_eq("run_40", pc_current, 32'h40);
    check_eq("hit_pred_taken", {31'b0, pred_taken}, 32'h1);
    check_eq("hit_pred_target", pred_target, 32'h100);
    step(); check_eq("pred_follow", pc_current, 32'h100);
    // three not-taken: 10 -> 01 -> 00 -> 00 (saturates low)
    pc_enable = 1'b0;
    btb_upd(32'h40, 32'h0, 1'b0);
    btb_upd(32'h40, 32'h0, 1'b0);
    btb_upd(32'h40, 32'h0, 1'b0);
    redirect_to(32'h40);
    check_eq("nt_pc40", pc_current, 32'h40);
    check_eq("nt_pred0", {31'b0, pred_taken}, 32'h0);
    check_eq("nt_target0", pred_target, 32'h0);
    pc_enable = 1'b1;
    step(); check_eq("nt_seq44", pc_current, 32'h44);

    // 4. retrain 0x40 to WT, then trap vs redirect
    pc_enable = 1'b0;
    btb_upd(32'h40, 32'h100, 1'b1);
    btb_upd(32'h40, 32'h100, 1'b1);
    redirect_to(32'h40);
    check_eq("retrain_pred", {31'b0, pred_taken}, 32'h1);
    trap_valid = 1'b1; trap_addr = 32'h8000_0000;
    redirect_valid = 1'b1; redirect_addr = 32'h300;
    pc_enable = 1'b1;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0; pc_enable = 1'b0;
    check_eq("trap_wins", pc_current, 32'h8000_0000);
    redirect_to(32'h303);
    check_eq("redir_align", pc_current, 32'h300);

    // 5. aliasing at index 0: 0x40 (tag 1) replaced by 0x80 (tag 2)
    redirect_to(32'h40);
    check_eq("alias_pre_hit", {31'b0, pred_taken}, 32'h1);
    btb_upd_valid = 1'b1; btb_upd_pc = 32'h80; btb_upd_target = 32'h500; btb_upd_taken = 1'b1;
    #1;
    check_eq("rbw_old_taken", {31'b0, pred_taken}, 32'h1);
    check_eq("rbw_old_target", pred_target, 32'h100);
    step();
    btb_upd_valid = 1'b0;
    check_eq("alias_40_miss", {31'b0, pred_taken}, 32'h0);
    check_eq("alias_40_target", pred_target, 32'h0);
    redirect_to(32'h80);
    check_eq("alias_80_hit", {31'b0, pred_taken}, 32'h1);
    check_eq("alias_80_target", pred_target, 32'h500);
    // allocated as WT: one not-taken drops below the taken threshold
    btb_upd(32'h80, 32'h0, 1'b0);
    check_eq("alloc_wt", {31'b0, pred_taken}, 32'h0);
    // 01 -> 10 -> 11 -> 11, then one not-taken -> 10 (still taken)
    btb_upd(32'h80, 32'h500, 1'b1);
    btb_upd(32'h80, 32'h500, 1'b1);
    btb_upd(32'h80, 32'h500, 1'b1);
    btb_upd(32'h80, 32'h0, 1'b0);
    check_eq("sat_high", {31'b0, pred_taken}, 32'h1);

    // 6. wrap at top of the address space
    redirect_to(32'hFFFF_FFFC);
    check_eq("wrap_pc", pc_current, 32'hFFFF_FFFC);
    check_eq("wrap_pc_next", pc_next, 32'h0);
    pc_enable = 1'b1;
    step(); check_eq("wrap_zero", pc_current, 32'h0);

    // mid-run asynchronous reset discards a pending redirect and clears the BTB
    pc_enable = 1'b0;
    redirect_to(32'h80);
    check_eq("pre_rst_pred", {31'b0, pred_taken}, 32'h1);
    redirect_valid = 1'b1; redirect_addr = 32'h900;
    #2 rstn = 1'b0;
    #1;
    check_eq("async_rst_pc", pc_current, 32'h0);
    check_eq("async_rst_pred", {31'b0, pred_taken}, 32'h0);
    step();
    check_eq("rst_discard", pc_current, 32'h0);
    redirect_valid = 1'b0;
    rstn = 1'b1;
    redirect_to(32'h80);
    check_eq("post_rst_pc", pc_current, 32'h80);
    check_eq("post_rst_btb_clear", {31'b0, pred_taken}, 32'h0);
    check_eq("post_rst_target", pred_target, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
